mux_rr_sched: RTL and testbench

Round-robin selector scheduler that sits directly upstream of the 8-channel, 32-bit mux and drives its `selector_i`. It watches per-channel request lines and grants one channel at a time for a bounded burst of beats under a valid/ready handshake. It inserts one dead cycle between grants so the registered mux output settles before the next channel is forwarded.

---
 rtl/mux_rr_sched_if.sv | 44 ++++
 rtl/mux_rr_sched.sv | 140 ++++++++++++++
 tb/tb_mux_rr_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_sched_if
// Description : Handshake/selector bundle between the round-robin scheduler,
//               the per-channel requesters, the downstream sink and the mux.
//               The master modport is the scheduler side; the slave modport
//               is the requester/sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_sched_if #(
  parameter int NUM_CH    = 8,
  parameter int SEL_WIDTH = 3
);

  logic                 enable_i;
  logic [NUM_CH-1:0]    req_i;
  logic                 ready_i;
  logic [SEL_WIDTH-1:0] selector_o;
  logic [NUM_CH-1:0]    grant_o;
  logic                 valid_o;
  logic                 last_o;

  modport master (
    input  enable_i,
    input  req_i,
    input  ready_i,
    output selector_o,
    output grant_o,
    output valid_o,
    output last_o
  );

  modport slave (
    output enable_i,
    output req_i,
    output ready_i,
    input  selector_o,
    input  grant_o,
    input  valid_o,
    input  last_o
  );

endinterface
`default_nettype wire

// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_sched
// Description : Round-robin selector scheduler for the 8-channel mux. Grants
//               one requesting channel at a time for a burst of up to
//               BURST_LEN beats under valid/ready, then spends one dead
//               cycle (SWITCH) so the registered mux output settles before
//               the next channel is forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
  parameter int NUM_CH    = 8,
  parameter int SEL_WIDTH = 3,
  parameter int BURST_LEN = 4
) (
  input  wire logic      clk_i,
  input  wire logic      arst_i,
  mux_rr_sched_if.master bus
);

  // Beat counter needs at least one bit even for single-beat bursts.
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]     C_LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [SEL_WIDTH-1:0] C_LAST_CH   = SEL_WIDTH'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t               state_q,    state_d;
  logic [SEL_WIDTH-1:0] selector_q, selector_d;
  logic [NUM_CH-1:0]    grant_q,    grant_d;
  logic                 valid_q,    valid_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [SEL_WIDTH-1:0] last_ch_q,  last_ch_d;

  logic [SEL_WIDTH-1:0] arb_idx;
  logic [SEL_WIDTH-1:0] arb_win;
  logic                 arb_found;
  logic                 cur_req;
  logic                 final_beat;

  // Request line of the channel currently on the selector. While granted,
  // a low request marks the offered beat as the final one.
  assign cur_req    = bus.req_i[selector_q];
  assign final_beat = (beat_cnt_q == C_LAST_BEAT) || !cur_req;

  // Round-robin scan: start just after the last granted channel and wrap.
  // NUM_CH is a power of two, so truncating the sum to SEL_WIDTH bits is the
  // modulo; the final iteration revisits last_ch itself so a lone requester
  // is re-granted.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = last_ch_q;
    arb_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      arb_idx = last_ch_q + SEL_WIDTH'(i);
      if (!arb_found && bus.req_i[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx;
      end
    end
  end

  // Next-state logic: arbitrate from IDLE/SWITCH, count beats in GRANT.
  always_comb begin
    state_d    = state_q;
    selector_d = selector_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    beat_cnt_d = beat_cnt_q;
    last_ch_d  = last_ch_q;

    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        // Both states arbitrate identically; only the fall-through differs
        // in name (SWITCH drops back to IDLE when nothing is granted).
        valid_d = 1'b0;
        grant_d = '0;
        state_d = ST_IDLE;
        if (bus.enable_i && arb_found) begin
          state_d    = ST_GRANT;
          selector_d = arb_win;
          grant_d    = NUM_CH'(1) << arb_win;
          valid_d    = 1'b1;
          last_ch_d  = arb_win;
          beat_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        // Without ready nothing moves, even if the request has dropped:
        // the final beat is still owed to the sink.
        if (bus.ready_i) begin
          if (final_beat) begin
            state_d = ST_SWITCH;
            valid_d = 1'b0;
            grant_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves channel 0 first in round-robin order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_IDLE;
      selector_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      beat_cnt_q <= '0;
      last_ch_q  <= C_LAST_CH;
    end else begin
      state_q    <= state_d;
      selector_q <= selector_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      beat_cnt_q <= beat_cnt_d;
      last_ch_q  <= last_ch_d;
    end
  end

  assign bus.selector_o = selector_q;
  assign bus.grant_o    = grant_q;
  assign bus.valid_o    = valid_q;
  assign bus.last_o     = valid_q && final_beat;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_sched
// Description : Self-checking bench for mux_rr_sched. One instance with
//               BURST_LEN=4 driven from a vector table plus a round-robin
//               sequence, and one instance with BURST_LEN=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sched;

  typedef struct {
    logic       arst;
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       vld;
    logic       lst;
  } vec_t;

  logic clk;
  logic arst0;
  logic arst1;
  int   n_total;
  int   n_pass;
  vec_t tbl[$];

  mux_rr_sched_if #(.NUM_CH(8), .SEL_WIDTH(3)) bus0 ();
  mux_rr_sched_if #(.NUM_CH(8), .SEL_WIDTH(3)) bus1 ();

  mux_rr_sched #(.NUM_CH(8), .SEL_WIDTH(3), .BURST_LEN(4)) dut0 (
    .clk_i  (clk),
    .arst_i (arst0),
    .bus    (bus0.master)
  );

  mux_rr_sched #(.NUM_CH(8), .SEL_WIDTH(3), .BURST_LEN(1)) dut1 (
    .clk_i  (clk),
    .arst_i (arst1),
    .bus    (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic a, input logic e, input logic [7:0] r,
                              input logic rd, input logic [2:0] s,
                              input logic [7:0] g, input logic v, input logic l);
    vec_t x;
    x.arst = a; x.en = e; x.req = r; x.rdy = rd;
    x.sel = s; x.gnt = g; x.vld = v; x.lst = l;
    return x;
  endfunction

  task automatic check(input string name,
                       input logic [2:0] sel, input logic [7:0] gnt,
                       input logic vld, input logic lst,
                       input logic [2:0] esel, input logic [7:0] egnt,
                       input logic evld, input logic elst);
    n_total++;
    if (sel === esel && gnt === egnt && vld === evld && lst === elst) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got sel=%0d grant=%02h valid=%b last=%b, want sel=%0d grant=%02h valid=%b last=%b",
               name, sel, gnt, vld, lst, esel, egnt, evld, elst);
    end
  endtask

  // One cycle on the BURST_LEN=4 instance: drive at negedge, check 1ns later.
  task automatic step0(input vec_t v, input string name);
    @(negedge clk);
    arst0         = v.arst;
    bus0.enable_i = v.en;
    bus0.req_i    = v.req;
    bus0.ready_i  = v.rdy;
    #1;
    check(name, bus0.selector_o, bus0.grant_o, bus0.valid_o, bus0.last_o,
          v.sel, v.gnt, v.vld, v.lst);
  endtask

  // One cycle on the BURST_LEN=1 instance.
  task automatic step1(input vec_t v, input string name);
    @(negedge clk);
    arst1         = v.arst;
    bus1.enable_i = v.en;
    bus1.req_i    = v.req;
    bus1.ready_i  = v.rdy;
    #1;
    check(name, bus1.selector_o, bus1.grant_o, bus1.valid_o, bus1.last_o,
          v.sel, v.gnt, v.vld, v.lst);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    arst0 = 1'b1; arst1 = 1'b1;
    bus0.enable_i = 1'b0; bus0.req_i = '0; bus0.ready_i = 1'b0;
    bus1.enable_i = 1'b0; bus1.req_i = '0; bus1.ready_i = 1'b0;

    //            arst en req    rdy | sel gnt   vld lst
    // Single requester, ch0, 4-beat bursts separated by one dead cycle
    tbl.push_back(mk(1, 1, 8'h01, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h01, 1, 1));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1,   0, 8'h01, 1, 0));
    // Ch3: one beat, request drops, ready low 5 cycles, final beat owed
    tbl.push_back(mk(1, 1, 8'h08, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 1,   3, 8'h08, 1, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0,   3, 8'h08, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0,   3, 8'h08, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0,   3, 8'h08, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0,   3, 8'h08, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 0,   3, 8'h08, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 1,   3, 8'h08, 1, 1));
    tbl.push_back(mk(0, 1, 8'h00, 1,   3, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1,   3, 8'h00, 0, 0));
    // Enable drops during beat 2: burst completes, then IDLE until re-enabled
    tbl.push_back(mk(1, 1, 8'hFF, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1,   0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1,   0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1,   0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1,   0, 8'h01, 1, 1));
    tbl.push_back(mk(0, 0, 8'hFF, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1,   1, 8'h02, 1, 0));
    // Reset during beat 2 of a ch5 burst, then restart scan from ch0
    tbl.push_back(mk(1, 1, 8'h20, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 1,   5, 8'h20, 1, 0));
    tbl.push_back(mk(1, 1, 8'hA0, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   5, 8'h20, 1, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   5, 8'h20, 1, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   5, 8'h20, 1, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   5, 8'h20, 1, 1));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   5, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA0, 1,   7, 8'h80, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step0(tbl[i], $sformatf("vec%0d", i));
    end

    // All channels requesting: grant order 0..7,0, four beats each,
    // one dead cycle between bursts.
    step0(mk(1, 1, 8'hFF, 1, 0, 8'h00, 0, 0), "rr_reset");
    step0(mk(0, 1, 8'hFF, 1, 0, 8'h00, 0, 0), "rr_idle");
    for (int n = 0; n < 9; n++) begin
      logic [2:0] ch;
      ch = 3'(n % 8);
      for (int b = 0; b < 4; b++) begin
        step0(mk(0, 1, 8'hFF, 1, ch, 8'h01 << ch, 1, (b == 3)),
              $sformatf("rr_burst%0d_beat%0d", n, b));
      end
      step0(mk(0, 1, 8'hFF, 1, ch, 8'h00, 0, 0), $sformatf("rr_switch%0d", n));
    end

    // BURST_LEN=1 instance: channels 0 and 4 alternate, one beat each.
    step1(mk(1, 1, 8'h11, 1, 0, 8'h00, 0, 0), "bl1_reset");
    step1(mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 0), "bl1_idle");
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ch;
      ch = (k % 2 == 1) ? 3'd4 : 3'd0;
      step1(mk(0, 1, 8'h11, 1, ch, 8'h01 << ch, 1, 1), $sformatf("bl1_grant%0d", k));
      step1(mk(0, 1, 8'h11, 1, ch, 8'h00, 0, 0), $sformatf("bl1_switch%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
